mcdt_rx_demux: RTL and testbench
================================

// Module: mcdt_rx_demux
// PURPOSE
//  Receive-side counterpart of the mcdt arbiter/formatter: takes the merged mcdt output stream
//  (data, valid, 2-bit channel id) and demultiplexes it back into three per-channel FIFOs.
//  Each channel is drained through its own valid/ready port, and fill level is reported per channel.
//  The mcdt stream has no backpressure, so overflow and illegal ids are dropped and flagged sticky.
//  Sits between mcdt_o and downstream per-channel consumers, and serves as loopback sink in block benches.
// PARAMETERS
//  DATA_W      32   width of mcdt_data_i and chN_data_o
//  FIFO_DEPTH  16   entries per channel FIFO; power of 2, >=2
//  CNT_W       5    level width = $clog2(FIFO_DEPTH)+1
// PORTS
//  clk_i         in   1       sole clock, all state on rising edge
//  rst_i         in   1       reset
//  mcdt_data_i   in   DATA_W  merged stream data
//  mcdt_val_i    in   1       merged stream valid, one word per cycle, no ready
//  mcdt_id_i     in   2       target channel 0..2; 3 illegal
//  chN_data_o    out  DATA_W  (N=0,1,2) head-of-FIFO word; 0 when FIFO empty
//  chN_valid_o   out  1       (N=0,1,2) FIFO non-empty
//  chN_ready_i   in   1       (N=0,1,2) consumer accepts head word
//  chN_level_o   out  CNT_W   (N=0,1,2) current occupancy 0..FIFO_DEPTH
//  ovf_o         out  3       sticky per-channel overflow flag, bit N = channel N
//  bad_id_o      out  1       sticky, set when a word with id 3 is received
//  drop_cnt_o    out  8       total dropped words (overflow + bad id), saturates at 255
//  clr_err_i     in   1       synchronous clear of ovf_o, bad_id_o, drop_cnt_o
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-high.
//  Reset (rst_i=1, any time incl. mid-transfer): all FIFOs empty, pointers 0, every chN_valid_o=0,
//   chN_data_o=0, chN_level_o=0, ovf_o=0, bad_id_o=0, drop_cnt_o=0. FIFO contents are discarded.
//  Push: on an edge with mcdt_val_i=1, id=N<3 and FIFO N not full, mcdt_data_i is written to FIFO N.
//   Latency: the word appears on chN_data_o with chN_valid_o=1 one cycle after the push edge,
//   if the FIFO was empty.
//  Pop: on an edge with chN_valid_o=1 and chN_ready_i=1, the head is consumed and the next entry
//   (or 0/valid=0 if none) is shown on the following cycle. Show-ahead FIFO; data is stable while
//   valid=1 and ready=0.
//  Simultaneous push+pop, same channel, not full: both occur and level is unchanged.
//   If empty, the pushed word becomes head next cycle.
//  Full: a push to a full FIFO is dropped even if a pop occurs on the same edge. ovf_o[N] is set and
//   drop_cnt_o is incremented. The pop still happens, so level drops by 1.
//  id==3 with mcdt_val_i=1: word dropped, bad_id_o set, drop_cnt_o incremented. No FIFO changes.
//  drop_cnt_o: +1 per dropped word (at most 1 per cycle), holds at 255.
//  clr_err_i: clears ovf_o, bad_id_o and drop_cnt_o on the edge. If an error occurs on the same
//   edge, the error wins: flag is 1 and drop_cnt_o=1.
//  Pointers: log2(FIFO_DEPTH)-bit read/write pointers wrap modulo FIFO_DEPTH. Level is tracked
//   separately in CNT_W bits, where full means level==FIFO_DEPTH.
//  mcdt_val_i=0: inputs are ignored regardless of id/data. Channels are fully independent.
// TESTING
//  1 Reset: assert rst_i mid-stream with FIFO0 holding 5 words -> all valid=0, level=0, flags=0 immediately.
//  2 Routing: push 0xA0/id0, 0xB1/id1, 0xC2/id2 on consecutive cycles with all ready=1 ->
//    each chN_valid_o pulses 1 cycle with the matching word, and levels return to 0.
//  3 Ordering/wrap: ready0=0, push 40 words 0..39 to ch0 in bursts of 10, draining in between ->
//    ch0 outputs 0..39 in order with no loss, and pointers wrap twice.
//  4 Overflow: ready1=0, push 18 words to ch1 -> level1=16, ovf_o=3'b010, drop_cnt_o=2.
//    Draining then yields words 0..15.
//  5 Full+pop same edge: ch2 full, ready2=1 and push on same edge -> push dropped, ovf_o[2]=1, level=15.
//  6 Bad id/clear: push id=3 -> bad_id_o=1, drop_cnt_o+1, no valid. clr_err_i together with another
//    id 3 -> bad_id_o=1, drop_cnt_o=1. clr_err_i alone -> all flags 0.

Source files
------------

// File: rtl/mcdt_rx_demux_if.sv
// mcdt_rx_demux_if
// Bundles the merged mcdt input stream, the three per-channel show-ahead
// drain ports and the sticky error reporting of the receive demultiplexer.
//
// Signals:
//   mcdt_data_i/mcdt_val_i/mcdt_id_i  merged stream word, valid and target channel (3 illegal)
//   chN_data_o/chN_valid_o            head-of-FIFO word and non-empty flag, N = 0..2
//   chN_ready_i                       consumer accepts the head word
//   chN_level_o                       FIFO occupancy 0..FIFO_DEPTH
//   ovf_o/bad_id_o/drop_cnt_o         sticky overflow per channel, sticky bad id, drop counter
//   clr_err_i                         synchronous clear of the error reporting
//
// Modports:
//   slave   the demultiplexer itself (receives the stream, serves the channels)
//   master  the environment (drives the stream, consumes the channels)
interface mcdt_rx_demux_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
);
    logic [DATA_W-1:0] mcdt_data_i;
    logic              mcdt_val_i;
    logic [1:0]        mcdt_id_i;

    logic [DATA_W-1:0] ch0_data_o;
    logic [DATA_W-1:0] ch1_data_o;
    logic [DATA_W-1:0] ch2_data_o;
    logic              ch0_valid_o;
    logic              ch1_valid_o;
    logic              ch2_valid_o;
    logic              ch0_ready_i;
    logic              ch1_ready_i;
    logic              ch2_ready_i;
    logic [CNT_W-1:0]  ch0_level_o;
    logic [CNT_W-1:0]  ch1_level_o;
    logic [CNT_W-1:0]  ch2_level_o;

    logic [2:0]        ovf_o;
    logic              bad_id_o;
    logic [7:0]        drop_cnt_o;
    logic              clr_err_i;

    modport slave (
        input  mcdt_data_i, mcdt_val_i, mcdt_id_i,
        input  ch0_ready_i, ch1_ready_i, ch2_ready_i,
        input  clr_err_i,
        output ch0_data_o, ch1_data_o, ch2_data_o,
        output ch0_valid_o, ch1_valid_o, ch2_valid_o,
        output ch0_level_o, ch1_level_o, ch2_level_o,
        output ovf_o, bad_id_o, drop_cnt_o
    );

    modport master (
        output mcdt_data_i, mcdt_val_i, mcdt_id_i,
        output ch0_ready_i, ch1_ready_i, ch2_ready_i,
        output clr_err_i,
        input  ch0_data_o, ch1_data_o, ch2_data_o,
        input  ch0_valid_o, ch1_valid_o, ch2_valid_o,
        input  ch0_level_o, ch1_level_o, ch2_level_o,
        input  ovf_o, bad_id_o, drop_cnt_o
    );
endinterface

// File: rtl/mcdt_rx_demux.sv
// mcdt_rx_demux
// Receive-side counterpart of the mcdt arbiter: splits the merged mcdt stream
// back into three independent show-ahead FIFOs, one per channel. The stream
// has no backpressure, so words for a full FIFO or with the illegal id 3 are
// dropped and reported through sticky flags and a saturating drop counter.
//
// Ports:
//   clk_i   sole clock, all state on the rising edge
//   rst_i   asynchronous active-high reset, empties every FIFO and clears errors
//   bus     mcdt_rx_demux_if.slave: merged stream in, three drain ports out,
//           per-channel levels, ovf_o/bad_id_o/drop_cnt_o and clr_err_i
module mcdt_rx_demux #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mcdt_rx_demux_if.slave     bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int NCH   = 3;

    logic [DATA_W-1:0] mem      [NCH][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr   [NCH];
    logic [PTR_W-1:0]  wr_ptr   [NCH];
    logic [CNT_W-1:0]  level    [NCH];
    logic [DATA_W-1:0] head_data[NCH];

    logic [NCH-1:0] ready_vec;
    logic [NCH-1:0] valid_vec;
    logic [NCH-1:0] full_vec;
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic [NCH-1:0] ovf_evt;
    logic           bad_evt;
    logic           drop_evt;

    logic [NCH-1:0] ovf_q;
    logic           bad_id_q;
    logic [7:0]     drop_cnt_q;

    assign ready_vec = {bus.ch2_ready_i, bus.ch1_ready_i, bus.ch0_ready_i};

    // Per-channel handshake decode. Fullness is judged on the level before
    // this edge, so a push into a full FIFO is dropped even when a pop frees
    // a slot on the same edge. The head word is forced to zero when empty.
    always_comb begin
        valid_vec = '0;
        full_vec  = '0;
        push      = '0;
        pop       = '0;
        ovf_evt   = '0;
        for (int c = 0; c < NCH; c++) begin
            head_data[c] = '0;
            valid_vec[c] = (level[c] != '0);
            full_vec[c]  = (level[c] == CNT_W'(FIFO_DEPTH));
            if (bus.mcdt_val_i && (bus.mcdt_id_i == 2'(c))) begin
                push[c]    = !full_vec[c];
                ovf_evt[c] = full_vec[c];
            end
            pop[c] = valid_vec[c] && ready_vec[c];
            if (valid_vec[c]) begin
                head_data[c] = mem[c][rd_ptr[c]];
            end
        end
        bad_evt  = bus.mcdt_val_i && (bus.mcdt_id_i == 2'd3);
        drop_evt = bad_evt || (|ovf_evt);
    end

    // Pointers wrap naturally because the depth is a power of two; the level
    // is kept separately so that full and empty stay distinguishable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NCH; c++) begin
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                level[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (push[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + 1'b1;
                end
                if (pop[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + 1'b1;
                end
                level[c] <= level[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
            end
        end
    end

    // Storage needs no reset: reset empties the FIFOs through the level and
    // pointers, which makes any stale contents unreachable.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NCH; c++) begin
            if (push[c]) begin
                mem[c][wr_ptr[c]] <= bus.mcdt_data_i;
            end
        end
    end

    // Sticky error reporting. A clear on the same edge as a new error still
    // records that error, so the clear branch loads the current events.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q      <= '0;
            bad_id_q   <= 1'b0;
            drop_cnt_q <= '0;
        end else if (bus.clr_err_i) begin
            ovf_q      <= ovf_evt;
            bad_id_q   <= bad_evt;
            drop_cnt_q <= drop_evt ? 8'd1 : 8'd0;
        end else begin
            ovf_q    <= ovf_q | ovf_evt;
            bad_id_q <= bad_id_q | bad_evt;
            if (drop_evt && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign bus.ch0_data_o  = head_data[0];
    assign bus.ch1_data_o  = head_data[1];
    assign bus.ch2_data_o  = head_data[2];
    assign bus.ch0_valid_o = valid_vec[0];
    assign bus.ch1_valid_o = valid_vec[1];
    assign bus.ch2_valid_o = valid_vec[2];
    assign bus.ch0_level_o = level[0];
    assign bus.ch1_level_o = level[1];
    assign bus.ch2_level_o = level[2];
    assign bus.ovf_o       = ovf_q;
    assign bus.bad_id_o    = bad_id_q;
    assign bus.drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_mcdt_rx_demux.sv
// tb_mcdt_rx_demux
// Drives the demultiplexer with directed and random traffic. The stimulus
// side keeps a queue-per-channel reference model and pushes every accepted
// word into that channel's expected queue; the monitor on the falling edge
// compares what the DUT presents and retires words when they are consumed.
module tb_mcdt_rx_demux;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;

    logic clk;
    logic rst;

    int checks;
    int errors;

    mcdt_rx_demux_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    mcdt_rx_demux #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expQ holds the words each channel still owes, occ is
    // the occupancy the DUT will have after the upcoming edge, and the cur*
    // values describe what the DUT must show right now.
    logic [DATA_W-1:0] expQ[3][$];
    int                occ[3];
    int                curLevel[3];
    logic [2:0]        rdyNow;
    logic [2:0]        ovfM, curOvf;
    logic              badM, curBad;
    int                dropM, curDrop;
    bit                monEn;

    task automatic compareVal(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge and advances the
    // model to the state the DUT reaches on the following edge.
    task automatic applyStimulus(input logic v, input logic [1:0] id, input logic [31:0] d,
                                 input logic [2:0] rdy, input logic clr);
        logic [2:0] ovfEvt;
        logic       badEvt;
        @(posedge clk);
        #1;
        bus.mcdt_val_i  = v;
        bus.mcdt_id_i   = id;
        bus.mcdt_data_i = d;
        bus.ch0_ready_i = rdy[0];
        bus.ch1_ready_i = rdy[1];
        bus.ch2_ready_i = rdy[2];
        bus.clr_err_i   = clr;
        rdyNow = rdy;
        for (int c = 0; c < 3; c++) curLevel[c] = occ[c];
        curOvf  = ovfM;
        curBad  = badM;
        curDrop = dropM;
        ovfEvt = '0;
        badEvt = v && (id == 2'd3);
        for (int c = 0; c < 3; c++) begin
            int delta;
            delta = (rdy[c] && occ[c] > 0) ? -1 : 0;
            if (v && id == 2'(c)) begin
                if (occ[c] == DEPTH) begin
                    ovfEvt[c] = 1'b1;
                end else begin
                    expQ[c].push_back(d);
                    delta += 1;
                end
            end
            occ[c] += delta;
        end
        if (clr) begin
            ovfM  = ovfEvt;
            badM  = badEvt;
            dropM = (badEvt || ovfEvt != 0) ? 1 : 0;
        end else begin
            ovfM = ovfM | ovfEvt;
            badM = badM | badEvt;
            if ((badEvt || ovfEvt != 0) && dropM < 255) dropM++;
        end
    endtask

    task automatic idle(input int n, input logic [2:0] rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 32'h0, rdy, 1'b0);
    endtask

    // Asynchronous reset asserted just after an edge; outputs must clear at
    // once, without waiting for the next clock.
    task automatic resetDut();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.mcdt_val_i = 1'b0;
        bus.clr_err_i  = 1'b0;
        bus.ch0_ready_i = 1'b0;
        bus.ch1_ready_i = 1'b0;
        bus.ch2_ready_i = 1'b0;
        rdyNow = '0;
        for (int c = 0; c < 3; c++) begin
            expQ[c].delete();
            occ[c] = 0;
            curLevel[c] = 0;
        end
        ovfM = '0; curOvf = '0;
        badM = 1'b0; curBad = 1'b0;
        dropM = 0; curDrop = 0;
        #1;
        compareVal("rst_ch0_valid", 32'(bus.ch0_valid_o), 32'd0);
        compareVal("rst_ch0_level", 32'(bus.ch0_level_o), 32'd0);
        compareVal("rst_ch0_data", bus.ch0_data_o, 32'd0);
        compareVal("rst_ovf", 32'(bus.ovf_o), 32'd0);
        compareVal("rst_drop", 32'(bus.drop_cnt_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every falling edge compare the visible state of each channel
    // and the error reporting; retire the head word when it is consumed.
    task automatic checkOutput();
        logic [DATA_W-1:0] d[3];
        logic              v[3];
        logic [CNT_W-1:0]  l[3];
        d = '{bus.ch0_data_o, bus.ch1_data_o, bus.ch2_data_o};
        v = '{bus.ch0_valid_o, bus.ch1_valid_o, bus.ch2_valid_o};
        l = '{bus.ch0_level_o, bus.ch1_level_o, bus.ch2_level_o};
        for (int c = 0; c < 3; c++) begin
            compareVal($sformatf("ch%0d_level", c), 32'(l[c]), 32'(curLevel[c]));
            if (curLevel[c] == 0) begin
                compareVal($sformatf("ch%0d_valid", c), 32'(v[c]), 32'd0);
                compareVal($sformatf("ch%0d_data_empty", c), d[c], 32'd0);
            end else begin
                compareVal($sformatf("ch%0d_valid", c), 32'(v[c]), 32'd1);
                if (expQ[c].size() > 0) begin
                    compareVal($sformatf("ch%0d_data", c), d[c], expQ[c][0]);
                    if (rdyNow[c]) void'(expQ[c].pop_front());
                end else begin
                    compareVal($sformatf("ch%0d_scoreboard_empty", c), 32'(expQ[c].size()), 32'd1);
                end
            end
        end
        compareVal("ovf", 32'(bus.ovf_o), 32'(curOvf));
        compareVal("bad_id", 32'(bus.bad_id_o), 32'(curBad));
        compareVal("drop_cnt", 32'(bus.drop_cnt_o), 32'(curDrop));
    endtask

    always @(negedge clk) begin
        if (monEn) checkOutput();
    end

    initial begin
        checks = 0;
        errors = 0;
        monEn  = 1'b0;
        rst    = 1'b1;
        bus.mcdt_val_i  = 1'b0;
        bus.mcdt_id_i   = 2'd0;
        bus.mcdt_data_i = '0;
        bus.ch0_ready_i = 1'b0;
        bus.ch1_ready_i = 1'b0;
        bus.ch2_ready_i = 1'b0;
        bus.clr_err_i   = 1'b0;
        rdyNow = '0;
        for (int c = 0; c < 3; c++) begin
            occ[c] = 0;
            curLevel[c] = 0;
        end
        ovfM = '0; curOvf = '0; badM = 1'b0; curBad = 1'b0; dropM = 0; curDrop = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        monEn = 1'b1;

        // Reset mid-stream with five words parked in channel 0.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd0, 32'h100 + i, 3'b000, 1'b0);
        applyStimulus(1'b0, 2'd0, 32'h0, 3'b000, 1'b0);
        @(negedge clk);
        compareVal("pre_rst_level0", 32'(bus.ch0_level_o), 32'd5);
        resetDut();

        // One word to each channel with every consumer ready.
        applyStimulus(1'b1, 2'd0, 32'hA0, 3'b111, 1'b0);
        applyStimulus(1'b1, 2'd1, 32'hB1, 3'b111, 1'b0);
        applyStimulus(1'b1, 2'd2, 32'hC2, 3'b111, 1'b0);
        idle(3, 3'b111);

        // Ordering across two pointer wraps: bursts of 10 with draining between.
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'd0, 32'(b * 10 + i), 3'b110, 1'b0);
            idle(12, 3'b111);
        end

        // Overflow on channel 1: 18 pushes into 16 slots.
        for (int i = 0; i < 18; i++) applyStimulus(1'b1, 2'd1, 32'(i), 3'b101, 1'b0);
        applyStimulus(1'b0, 2'd0, 32'h0, 3'b101, 1'b0);
        @(negedge clk);
        compareVal("ovf_level1", 32'(bus.ch1_level_o), 32'd16);
        compareVal("ovf_flags", 32'(bus.ovf_o), 32'b010);
        compareVal("ovf_drops", 32'(bus.drop_cnt_o), 32'd2);
        idle(20, 3'b111);
        applyStimulus(1'b0, 2'd0, 32'h0, 3'b111, 1'b1);

        // Full channel 2 with a pop and a push on the same edge.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'd2, 32'h200 + i, 3'b011, 1'b0);
        applyStimulus(1'b1, 2'd2, 32'hDEAD, 3'b111, 1'b0);
        applyStimulus(1'b0, 2'd0, 32'h0, 3'b011, 1'b0);
        @(negedge clk);
        compareVal("fullpop_level2", 32'(bus.ch2_level_o), 32'd15);
        compareVal("fullpop_ovf2", 32'(bus.ovf_o[2]), 32'd1);
        idle(20, 3'b111);
        applyStimulus(1'b0, 2'd0, 32'h0, 3'b111, 1'b1);

        // Bad id, clear racing a bad id, then a plain clear.
        applyStimulus(1'b1, 2'd3, 32'hBAD, 3'b111, 1'b0);
        applyStimulus(1'b1, 2'd3, 32'hBAD, 3'b111, 1'b0);
        applyStimulus(1'b1, 2'd3, 32'hBAD, 3'b111, 1'b1);
        applyStimulus(1'b0, 2'd0, 32'h0, 3'b111, 1'b0);
        @(negedge clk);
        compareVal("clr_vs_bad_flag", 32'(bus.bad_id_o), 32'd1);
        compareVal("clr_vs_bad_drop", 32'(bus.drop_cnt_o), 32'd1);
        applyStimulus(1'b0, 2'd0, 32'h0, 3'b111, 1'b1);
        applyStimulus(1'b0, 2'd0, 32'h0, 3'b111, 1'b0);
        @(negedge clk);
        compareVal("clr_bad_flag", 32'(bus.bad_id_o), 32'd0);
        compareVal("clr_drop", 32'(bus.drop_cnt_o), 32'd0);

        // Drop counter saturation.
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 2'd3, 32'(i), 3'b111, 1'b0);
        applyStimulus(1'b0, 2'd0, 32'h0, 3'b111, 1'b0);
        @(negedge clk);
        compareVal("drop_saturate", 32'(bus.drop_cnt_o), 32'd255);
        applyStimulus(1'b0, 2'd0, 32'h0, 3'b111, 1'b1);

        // Random traffic with mixed backpressure, rare clears and one reset.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] id;
            logic [2:0] rdy;
            int sel;
            sel = int'($urandom_range(0, 9));
            id  = (sel == 9) ? 2'd3 : 2'(sel % 3);
            rdy = (i % 400 < 200) ? 3'($urandom_range(0, 7) & $urandom_range(0, 7))
                                  : 3'($urandom_range(0, 7) | $urandom_range(0, 7));
            if (i == 1500) resetDut();
            applyStimulus(($urandom_range(0, 3) != 0), id, $urandom, rdy,
                          ($urandom_range(0, 49) == 0));
        end
        idle(DEPTH + 4, 3'b111);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            compareVal($sformatf("ch%0d_drained", c), 32'(expQ[c].size()), 32'd0);
        end

        monEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
